imem_boot_ctrl: RTL and testbench

Boot and fetch controller placed in front of the 256 x 32-bit instruction memory. It loads a program from a byte stream into the memory through a write port. It holds the CPU in reset while loading and releases it when the load completes. After release it gates instruction fetch: it forwards memory read data and flags misaligned or out-of-range fetch addresses.

---
 rtl/imem_boot_ctrl_pkg.sv | 29 ++
 rtl/imem_boot_ctrl_if.sv | 44 ++++
 rtl/imem_byte_packer.sv | 42 ++++
 rtl/imem_boot_ctrl.sv | 128 ++++++++++++
 tb/tb_imem_boot_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types, constants and helpers for the instruction
//                memory boot/fetch controller.
//  Revision    : 1.0  initial release
// ============================================================================
package imem_pkg;

    localparam int          IMEM_ADDR_W    = 8;
    localparam logic [31:0] IMEM_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    // A fetch faults when the PC is not word aligned or points past the
    // last word of a 2**addr_w deep memory.
    function automatic logic fetch_fault_f(input logic [31:0] addr, input int addr_w);
        logic [31:0] w_hi;
        w_hi = addr >> (addr_w + 2);
        return (addr[1:0] != 2'b00) || (w_hi != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_boot_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_ctrl_if
//  Description : Boot stream, memory write/read and CPU fetch signals of the
//                instruction memory boot controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_boot_ctrl_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);
    logic              boot_start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_last;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [31:0]       fetch_addr;
    logic [ADDR_W-1:0] mem_raddr;
    logic [31:0]       mem_rdata;
    logic [31:0]       cpu_instr;
    logic              fetch_fault;
    logic              cpu_rst_n;
    logic [ADDR_W:0]   loaded_words;
    logic              overflow;

    // Controller side
    modport slave (
        input  boot_start, rx_valid, rx_data, rx_last, fetch_addr, mem_rdata,
        output rx_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, cpu_instr,
               fetch_fault, cpu_rst_n, loaded_words, overflow
    );

    // Host / memory / CPU side
    modport master (
        output boot_start, rx_valid, rx_data, rx_last, fetch_addr, mem_rdata,
        input  rx_ready, mem_we, mem_waddr, mem_wdata, mem_raddr, cpu_instr,
               fetch_fault, cpu_rst_n, loaded_words, overflow
    );
endinterface
`default_nettype wire

// File: rtl/imem_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_byte_packer
//  Description : Assembles little-endian bytes into 32-bit words, zero-filling
//                the unused upper bytes of a short final word.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_byte_packer (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_clear,
    input  wire logic        i_accept,
    input  wire logic [7:0]  i_byte,
    input  wire logic        i_last,
    output logic             o_word_valid,
    output logic [31:0]      o_word
);
    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic [31:0] w_word;

    // Bytes already held sit below lane r_cnt and everything above is zero,
    // so the incoming byte can simply be OR-ed into its lane.
    assign w_word       = r_word | ({24'd0, i_byte} << {r_cnt, 3'b000});
    assign o_word_valid = i_accept && ((r_cnt == 2'd3) || i_last);
    assign o_word       = w_word;

    // Byte counter and assembly register; cleared on each emitted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_clear || o_word_valid) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_accept) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= w_word;
        end
    end
endmodule
`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_ctrl
//  Description : Loads a program byte stream into instruction memory, holds
//                the CPU in reset while loading, then gates instruction fetch.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_boot_ctrl
    import imem_pkg::*;
#(
    parameter int          ADDR_W    = IMEM_ADDR_W,
    parameter logic [31:0] NOP_INSTR = IMEM_NOP_INSTR
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    imem_boot_ctrl_if.slave  bus
);
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(1) << ADDR_W;

    state_t            r_state;
    state_t            w_next;
    logic              w_rx_ready;
    logic              w_accept;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic              w_full;
    logic              w_fault;
    logic [31:0]       w_cpu_instr;
    logic              w_fetch_fault;

    logic [ADDR_W:0]   r_wptr;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_waddr;
    logic [31:0]       r_mem_wdata;
    logic              r_overflow;
    logic              r_cpu_rst_n;

    // boot_start wins over a byte in the same cycle, so the byte is refused.
    assign w_rx_ready = (r_state == LOAD) && !bus.boot_start;
    assign w_accept   = bus.rx_valid && w_rx_ready;
    assign w_full     = (r_wptr == C_DEPTH);
    assign w_fault    = fetch_fault_f(bus.fetch_addr, ADDR_W);

    imem_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (bus.boot_start),
        .i_accept     (w_accept),
        .i_byte       (bus.rx_data),
        .i_last       (bus.rx_last),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and fetch-gating outputs.
    always_comb begin
        w_next        = r_state;
        w_cpu_instr   = NOP_INSTR;
        w_fetch_fault = 1'b0;
        case (r_state)
            IDLE:    w_next = IDLE;
            LOAD:    if (w_accept && bus.rx_last) w_next = RELEASE;
            RELEASE: w_next = RUN;
            RUN: begin
                w_fetch_fault = w_fault;
                w_cpu_instr   = w_fault ? NOP_INSTR : bus.mem_rdata;
            end
            default: w_next = IDLE;
        endcase
        if (bus.boot_start) begin
            w_next = LOAD;
        end
    end

    // Memory write port, word pointer, overflow flag and CPU reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= 32'd0;
            r_overflow  <= 1'b0;
            r_cpu_rst_n <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (bus.boot_start) begin
                r_wptr      <= '0;
                r_overflow  <= 1'b0;
                r_cpu_rst_n <= 1'b0;
            end else begin
                // Once the memory is full, bytes are still drained but dropped.
                if (w_word_valid && !w_full) begin
                    r_mem_we    <= 1'b1;
                    r_mem_waddr <= r_wptr[ADDR_W-1:0];
                    r_mem_wdata <= w_word;
                    r_wptr      <= r_wptr + 1'b1;
                end
                if (w_accept && w_full) begin
                    r_overflow <= 1'b1;
                end
                if (r_state == RELEASE) begin
                    r_cpu_rst_n <= 1'b1;
                end
            end
        end
    end

    assign bus.rx_ready     = w_rx_ready;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_waddr    = r_mem_waddr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.mem_raddr    = bus.fetch_addr[ADDR_W+1:2];
    assign bus.cpu_instr    = w_cpu_instr;
    assign bus.fetch_fault  = w_fetch_fault;
    assign bus.cpu_rst_n    = r_cpu_rst_n;
    assign bus.loaded_words = r_wptr;
    assign bus.overflow     = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_boot_ctrl
//  Description : Self-checking bench; drives a 256-word and a 4-word instance
//                with the same stimulus and checks both against a model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_boot_ctrl;
    localparam logic [31:0] EXP_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_last = 1'b0;
    logic [31:0] fetch_addr = 32'd0;
    logic [31:0] mem_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    int          wa8[$];
    logic [31:0] wd8[$];
    int          wa2[$];
    logic [31:0] wd2[$];

    imem_boot_ctrl_if #(.ADDR_W(8)) if8 ();
    imem_boot_ctrl_if #(.ADDR_W(2)) if2 ();

    assign if8.boot_start = boot_start;
    assign if8.rx_valid   = rx_valid;
    assign if8.rx_data    = rx_data;
    assign if8.rx_last    = rx_last;
    assign if8.fetch_addr = fetch_addr;
    assign if8.mem_rdata  = mem_rdata;
    assign if2.boot_start = boot_start;
    assign if2.rx_valid   = rx_valid;
    assign if2.rx_data    = rx_data;
    assign if2.rx_last    = rx_last;
    assign if2.fetch_addr = fetch_addr;
    assign if2.mem_rdata  = mem_rdata;

    imem_boot_ctrl #(.ADDR_W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    imem_boot_ctrl #(.ADDR_W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    always #5 clk = ~clk;

    // Record every memory write seen by each instance.
    always @(posedge clk) begin
        if (if8.mem_we === 1'b1) begin
            wa8.push_back(int'(if8.mem_waddr));
            wd8.push_back(if8.mem_wdata);
        end
        if (if2.mem_we === 1'b1) begin
            wa2.push_back(int'(if2.mem_waddr));
            wd2.push_back(if2.mem_wdata);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Boot, stream a program (rx_last on the final byte), then compare the
    // writes, counters and release timing against the model.
    task automatic load_prog(input logic [7:0] prog[$]);
        int          n;
        int          depth;
        int          nw;
        int          expw;
        int          idx;
        logic [31:0] w;
        int          act_sz;
        int          act_a;
        logic [31:0] act_d;
        int          act_ld;
        logic        act_ov;
        logic        exp_ov;
        n = prog.size();
        // A byte presented together with boot_start must be refused.
        boot_start = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'($urandom);
        rx_last    = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (if8.rx_ready !== 1'b0 || if2.rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL boot_prio_ready got %b/%b exp 0/0", if8.rx_ready, if2.rx_ready);
        end
        cyc();
        boot_start = 1'b0;
        rx_valid   = 1'b0;
        rx_last    = 1'b0;
        wa8.delete(); wd8.delete(); wa2.delete(); wd2.delete();
        checks++;
        if (if8.cpu_rst_n !== 1'b0 || if8.loaded_words !== 9'd0 || if8.overflow !== 1'b0 ||
            if2.cpu_rst_n !== 1'b0 || if2.loaded_words !== 3'd0 || if2.overflow !== 1'b0) begin
            errors++;
            $display("FAIL boot_clear got rst_n %b/%b loaded %0d/%0d ovf %b/%b exp 0 0 0",
                     if8.cpu_rst_n, if2.cpu_rst_n, if8.loaded_words, if2.loaded_words,
                     if8.overflow, if2.overflow);
        end
        checks++;
        if (if8.cpu_instr !== EXP_NOP || if8.fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL load_nop got %h/%b exp %h/0", if8.cpu_instr, if8.fetch_fault, EXP_NOP);
        end
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                cyc();
            end
            rx_valid = 1'b1;
            rx_data  = prog[i];
            rx_last  = (i == n - 1);
            #1;
            checks++;
            if (if8.rx_ready !== 1'b1 || if2.rx_ready !== 1'b1) begin
                errors++;
                $display("FAIL byte_ready[%0d] got %b/%b exp 1/1", i, if8.rx_ready, if2.rx_ready);
            end
            cyc();
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        checks++;
        if (if8.cpu_rst_n !== 1'b0 || if2.cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL release_hold got %b/%b exp 0/0", if8.cpu_rst_n, if2.cpu_rst_n);
        end
        cyc();
        checks++;
        if (if8.cpu_rst_n !== 1'b1 || if2.cpu_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL release_run got %b/%b exp 1/1", if8.cpu_rst_n, if2.cpu_rst_n);
        end
        // Model: words are groups of four little-endian bytes, zero padded;
        // only the first 'depth' words are stored.
        nw = (n + 3) / 4;
        for (int d = 0; d < 2; d++) begin
            depth  = (d == 0) ? 256 : 4;
            expw   = (nw < depth) ? nw : depth;
            exp_ov = (n > 4 * depth);
            act_sz = (d == 0) ? wa8.size() : wa2.size();
            act_ld = (d == 0) ? int'(if8.loaded_words) : int'(if2.loaded_words);
            act_ov = (d == 0) ? if8.overflow : if2.overflow;
            checks++;
            if (act_sz != expw) begin
                errors++;
                $display("FAIL write_count depth %0d got %0d exp %0d", depth, act_sz, expw);
            end
            for (int k = 0; k < expw && k < act_sz; k++) begin
                w = 32'd0;
                for (int b = 0; b < 4; b++) begin
                    idx = 4 * k + b;
                    if (idx < n) w = w | (32'(prog[idx]) << (8 * b));
                end
                act_a = (d == 0) ? wa8[k] : wa2[k];
                act_d = (d == 0) ? wd8[k] : wd2[k];
                checks++;
                if (act_a != k || act_d !== w) begin
                    errors++;
                    $display("FAIL write[%0d] depth %0d got @%0d %h exp @%0d %h",
                             k, depth, act_a, act_d, k, w);
                end
            end
            checks++;
            if (act_ld != expw || act_ov !== exp_ov) begin
                errors++;
                $display("FAIL counters depth %0d got loaded %0d ovf %b exp %0d %b",
                         depth, act_ld, act_ov, expw, exp_ov);
            end
        end
    endtask

    task automatic test_reset();
        fetch_addr = 32'h6;
        mem_rdata  = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (if8.cpu_rst_n !== 1'b0 || if8.rx_ready !== 1'b0 || if8.mem_we !== 1'b0 ||
            if8.mem_waddr !== 8'd0 || if8.mem_wdata !== 32'd0 || if8.loaded_words !== 9'd0 ||
            if8.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals8 got rst_n %b rdy %b we %b wa %h wd %h ld %0d ov %b exp all 0",
                     if8.cpu_rst_n, if8.rx_ready, if8.mem_we, if8.mem_waddr, if8.mem_wdata,
                     if8.loaded_words, if8.overflow);
        end
        rst_n = 1'b1;
        repeat (3) cyc();
        checks++;
        if (if8.cpu_instr !== EXP_NOP || if8.fetch_fault !== 1'b0 || if8.rx_ready !== 1'b0 ||
            if8.cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL idle_outs got instr %h fault %b rdy %b rst_n %b exp %h 0 0 0",
                     if8.cpu_instr, if8.fetch_fault, if8.rx_ready, if8.cpu_rst_n, EXP_NOP);
        end
    endtask

    task automatic test_basic();
        logic [7:0] p[$];
        p = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load_prog(p);
        checks++;
        if (wd8.size() != 2 || wd8[0] !== 32'h0000_0013 || wd8[1] !== 32'h0010_0093) begin
            errors++;
            $display("FAIL basic_words got n %0d", wd8.size());
        end
        fetch_addr = 32'h4;
        mem_rdata  = $urandom;
        #1;
        checks++;
        if (if8.cpu_instr !== mem_rdata || if8.fetch_fault !== 1'b0 || if8.mem_raddr !== 8'd1) begin
            errors++;
            $display("FAIL basic_fetch got %h f%b ra %h exp %h f0 ra 01",
                     if8.cpu_instr, if8.fetch_fault, if8.mem_raddr, mem_rdata);
        end
    endtask

    task automatic test_partial();
        logic [7:0] p[$];
        p = '{8'hAA, 8'hBB};
        load_prog(p);
        checks++;
        if (wd8.size() != 1 || wd8[0] !== 32'h0000_BBAA) begin
            errors++;
            $display("FAIL partial_word got n %0d", wd8.size());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] p[$];
        for (int i = 0; i < 20; i++) p.push_back(8'($urandom));
        load_prog(p);
        checks++;
        if (if2.overflow !== 1'b1 || if2.loaded_words !== 3'd4 || if8.overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow got ovf2 %b ld2 %0d ovf8 %b exp 1 4 0",
                     if2.overflow, if2.loaded_words, if8.overflow);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] a;
        logic        f8;
        logic        f2;
        logic [31:0] addrs[$];
        addrs = '{32'h6, 32'h400, 32'h4, 32'hC, 32'h10, 32'h3FC};
        for (int i = 0; i < 12; i++) begin
            case (i % 3)
                0:       addrs.push_back($urandom);
                1:       addrs.push_back($urandom & 32'h0000_03FF);
                default: addrs.push_back($urandom & 32'h0000_003C);
            endcase
        end
        foreach (addrs[i]) begin
            a          = addrs[i];
            fetch_addr = a;
            mem_rdata  = $urandom;
            #1;
            f8 = (a % 4 != 0) || (a >= 32'd1024);
            f2 = (a % 4 != 0) || (a >= 32'd16);
            checks++;
            if (if8.fetch_fault !== f8 || if8.cpu_instr !== (f8 ? EXP_NOP : mem_rdata) ||
                int'(if8.mem_raddr) != int'((a / 4) % 256)) begin
                errors++;
                $display("FAIL fetch8 pc %h got f%b %h ra %h exp f%b %h",
                         a, if8.fetch_fault, if8.cpu_instr, if8.mem_raddr, f8, f8 ? EXP_NOP : mem_rdata);
            end
            checks++;
            if (if2.fetch_fault !== f2 || if2.cpu_instr !== (f2 ? EXP_NOP : mem_rdata) ||
                int'(if2.mem_raddr) != int'((a / 4) % 4)) begin
                errors++;
                $display("FAIL fetch2 pc %h got f%b %h ra %h exp f%b %h",
                         a, if2.fetch_fault, if2.cpu_instr, if2.mem_raddr, f2, f2 ? EXP_NOP : mem_rdata);
            end
        end
    endtask

    // A load abandoned part-way must not leak bytes into the restarted load.
    task automatic test_boot_priority();
        logic [7:0] p[$];
        boot_start = 1'b1;
        cyc();
        boot_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            cyc();
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 6; i++) p.push_back(8'($urandom));
        load_prog(p);
    endtask

    task automatic test_random_loads();
        logic [7:0] p[$];
        for (int t = 0; t < 6; t++) begin
            p.delete();
            repeat ($urandom_range(1, 40)) p.push_back(8'($urandom));
            load_prog(p);
        end
    endtask

    task automatic test_reset_mid_load();
        boot_start = 1'b1;
        cyc();
        boot_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            cyc();
        end
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if (if8.cpu_rst_n !== 1'b0 || if8.rx_ready !== 1'b0 || if8.mem_we !== 1'b0 ||
            if8.mem_waddr !== 8'd0 || if8.mem_wdata !== 32'd0 || if8.loaded_words !== 9'd0 ||
            if8.overflow !== 1'b0 || if2.loaded_words !== 3'd0 || if2.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL midload_reset got rst_n %b rdy %b we %b wa %h wd %h ld %0d ov %b exp all 0",
                     if8.cpu_rst_n, if8.rx_ready, if8.mem_we, if8.mem_waddr, if8.mem_wdata,
                     if8.loaded_words, if8.overflow);
        end
        cyc();
        rst_n = 1'b1;
        wa8.delete(); wd8.delete(); wa2.delete(); wd2.delete();
        for (int i = 0; i < 10; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            rx_last  = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (if8.rx_ready !== 1'b0 || if2.rx_ready !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_ready[%0d] got %b/%b exp 0/0", i, if8.rx_ready, if2.rx_ready);
            end
            cyc();
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        cyc();
        checks++;
        if (wa8.size() != 0 || wa2.size() != 0 || if8.cpu_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got writes %0d/%0d rst_n %b exp 0/0 0",
                     wa8.size(), wa2.size(), if8.cpu_rst_n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_overflow();
        test_fetch();
        test_random_loads();
        test_boot_priority();
        test_fetch();
        test_reset_mid_load();
        test_basic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
`default_nettype wire
